// File: rtl/fpu_sched.sv
// Round-robin scheduler sharing one FPU between two requesters: accept, hold
// operands for LATENCY cycles, capture the result and return it tagged with the requester id.
module fpu_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 1,
    parameter int LATENCY    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic [DATA_WIDTH-1:0] i_req0_a,
    input  logic [DATA_WIDTH-1:0] i_req0_b,
    input  logic [INST_WIDTH-1:0] i_req0_inst,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic [DATA_WIDTH-1:0] i_req1_a,
    input  logic [DATA_WIDTH-1:0] i_req1_b,
    input  logic [INST_WIDTH-1:0] i_req1_inst,
    output logic [DATA_WIDTH-1:0] o_fpu_a,
    output logic [DATA_WIDTH-1:0] o_fpu_b,
    output logic [INST_WIDTH-1:0] o_fpu_inst,
    output logic                  o_fpu_valid,
    input  logic [DATA_WIDTH-1:0] i_fpu_data,
    input  logic                  i_fpu_valid,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_resp_data,
    output logic                  o_resp_id,
    output logic                  o_busy
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_range
        $error("fpu_sched: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic [3:0]  cnt;
    logic        grant;
    logic        accept;
    logic        capture;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant = i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            grant = ~last_grant;
        end
    end

    always_comb begin
        state_next   = state;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_resp_valid = 1'b0;
        o_busy       = (state != IDLE);
        accept       = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                o_req0_ready = i_req0_valid & ~grant;
                o_req1_ready = i_req1_valid & grant;
                accept       = o_req0_ready | o_req1_ready;
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                capture = (cnt == 4'd1) && i_fpu_valid;
                if (capture) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter saturates at 1 so a stalled FPU keeps the capture condition armed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant  <= 1'b1;
            cnt         <= 4'd0;
            o_resp_id   <= 1'b0;
            o_fpu_valid <= 1'b0;
        end else begin
            o_fpu_valid <= accept;
            if (accept) begin
                last_grant <= grant;
                o_resp_id  <= grant;
                cnt        <= 4'(LATENCY);
            end else if (state == EXEC && cnt > 4'd1) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fpu_a     <= '0;
            o_fpu_b     <= '0;
            o_fpu_inst  <= '0;
            o_resp_data <= '0;
        end else begin
            if (accept) begin
                o_fpu_a    <= grant ? i_req1_a : i_req0_a;
                o_fpu_b    <= grant ? i_req1_b : i_req0_b;
                o_fpu_inst <= grant ? i_req1_inst : i_req0_inst;
            end
            if (capture) begin
                o_resp_data <= i_fpu_data;
            end
        end
    end

endmodule

// File: doc/fpu_sched.md
# fpu_sched

Two-port round-robin scheduler that shares one single-precision FPU instance between two requesters. It accepts operations over valid/ready handshakes and holds operands stable on the FPU inputs for a programmable number of cycles. It then captures the FPU result and returns it, tagged with the requester ID, over a valid/ready response port. It sits between the issue logic of two clients and the FPU datapath (add when inst=0, multiply when inst=1).

## Interface
- DATA_WIDTH, 32, operand/result width
- INST_WIDTH, 1, opcode width (0 = add, 1 = mul)
- LATENCY, 1, cycles operands are held before result capture; legal 1..15
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req0_valid / i_req1_valid  in  1  request valid, per requester
- o_req0_ready / o_req1_ready  out  1  request accepted this cycle
- i_req0_a, i_req0_b / i_req1_a, i_req1_b  in  DATA_WIDTH  operands
- i_req0_inst / i_req1_inst  in  INST_WIDTH  opcode
- o_fpu_a, o_fpu_b  out  DATA_WIDTH  registered operands to FPU
- o_fpu_inst  out  INST_WIDTH  registered opcode to FPU
- o_fpu_valid  out  1  one-cycle pulse, first cycle of EXEC
- i_fpu_data  in  DATA_WIDTH  FPU result
- i_fpu_valid  in  1  FPU result valid (FPU currently ties high)
- o_resp_valid  out  1  response valid
- i_resp_ready  in  1  response consumer ready
- o_resp_data  out  DATA_WIDTH  captured result
- o_resp_id  out  1  requester that issued the op
- o_busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. One operation in flight at a time.
- IDLE, arbitration:
  - If exactly one valid: grant it.
  - If both valid: grant the requester != last_grant.
  - o_reqN_ready = (state==IDLE) & grant==N. This is combinational from valid and last_grant. Ready is never high for both requesters.
  - Handshake (valid & ready): register a, b, inst into o_fpu_*. Set id=N, last_grant=N, cnt=LATENCY. Go to EXEC.
- EXEC:
  - o_fpu_valid=1 in the first EXEC cycle only.
  - cnt decrements each cycle, saturating at 1.
  - When cnt==1 and i_fpu_valid=1: capture i_fpu_data into o_resp_data and go to RESP.
  - When cnt==1 and i_fpu_valid=0: stay in EXEC, operands held, until i_fpu_valid=1.
- RESP:
  - o_resp_valid=1. o_resp_data and o_resp_id are held stable.
  - On i_resp_ready=1, go to IDLE.
  - Requests are not accepted in RESP; all ready signals are 0.
- o_fpu_a, o_fpu_b and o_fpu_inst change only on an accept handshake. They hold their last values otherwise.
- Requester inputs are ignored except during the accept cycle.

## Timing
- Reset (async assert, sync release): state=IDLE, last_grant=1 (req0 wins the first tie), cnt=0, id=0. All outputs 0: o_fpu_a/b/inst, o_fpu_valid, o_resp_valid, o_resp_data, o_resp_id, o_busy, both ready signals.
- Reset mid-operation discards the in-flight op. No response is produced.
- Cycle 0: accept. Cycles 1..LATENCY: EXEC. Capture occurs at the edge ending cycle LATENCY (given i_fpu_valid=1).
- Cycle LATENCY+1: o_resp_valid=1 at the earliest.
- With i_resp_ready held high, the next accept is in cycle LATENCY+2. Peak throughput is one op per LATENCY+2 cycles.
- Backpressure: o_resp_valid stays high for any number of cycles until i_resp_ready=1.
- o_busy=1 from cycle 1 until IDLE is re-entered.
- Simultaneous requests: both valid in the same IDLE cycle produce strict alternation 0,1,0,1 for as long as both stay valid.
- A request held valid while the scheduler is not in IDLE is accepted on the first IDLE cycle, subject to arbitration.

## Test plan
- Single add, LATENCY=1: req0 a=0x3F800000, b=0x40000000, inst=0 → ready0 high in cycle 0; o_fpu_valid pulses in cycle 1; response 0x40400000, id=0, in cycle 2.
- Single mul, LATENCY=3: req1 a=0x40000000, b=0x40400000, inst=1 → response 0x40C00000, id=1, o_resp_valid first high in cycle 4; o_busy high cycles 1-4.
- Contention: both valid continuously for 4 ops, starting right after reset → grant order 0,1,0,1; never both ready in the same cycle; one response per op with the matching id.
- Backpressure: i_resp_ready=0 for 5 cycles during RESP → data and id stable for all 5 cycles; both ready signals 0; accept proceeds the cycle after i_resp_ready=1.
- FPU stall: i_fpu_valid=0 for 3 cycles after cnt reaches 1 → o_fpu_* stay constant; capture on the first cycle with i_fpu_valid=1; response correct.
- Reset mid-EXEC: assert i_rst_n=0 in cycle 1 → all outputs 0 immediately; no response after release; the next request is accepted normally, and req0 wins a tie.
